if_id_queue: RTL
================

Name: if_id_queue

Overview:
- Parametrised, multi-entry successor to the single IF/ID stage register.
- Buffers fetched instruction packets (pc, ir) between the fetch and decode stages.
- Uses a valid/ready handshake on both sides and supports a single-cycle flush on redirect (branch/jump resolved in EX).
- Lets fetch run ahead of decode stalls instead of freezing the whole front end.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- PC_WIDTH, 32, width of the pc field.
- INST_WIDTH, 32, width of the instruction word.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all entries (pipeline redirect).
- in_valid  in  1  fetch presents a packet.
- in_ready  out  1  queue can accept a packet; equals ~full, registered-state only.
- in_pc  in  PC_WIDTH  pc of the incoming packet.
- in_ir  in  INST_WIDTH  instruction of the incoming packet.
- out_valid  out  1  head entry is valid; equals ~empty.
- out_ready  in  1  decode consumes the head this cycle.
- out_pc  out  PC_WIDTH  pc of the head entry; 0 when empty.
- out_ir  out  INST_WIDTH  instruction of the head entry; 0 when empty.
- count  out  $clog2(DEPTH)+1  number of occupied entries, 0..DEPTH.

Behaviour:
- Reset (rst=1 at an edge):
  - head and tail pointers, count and storage all cleared to 0.
  - Next cycle: in_ready=1, out_valid=0, out_pc=0, out_ir=0, count=0.
  - rst has priority over flush, push and pop; reset mid-traffic drops everything.
- Push: in_valid & in_ready at an edge writes {in_pc,in_ir} at tail; tail increments modulo DEPTH.
- Pop: out_valid & out_ready at an edge advances head modulo DEPTH.
- Latency and bypass:
  - Minimum latency is 1 cycle: a packet pushed at edge N is visible on out_* after edge N.
  - There is no combinational in->out bypass.
  - There is no combinational ready->ready path; in_ready does not depend on out_ready.
- Full (count==DEPTH):
  - in_ready=0, so in_valid is ignored.
  - A pop the same cycle frees a slot for the next cycle only.
- Empty (count==0): out_valid=0 and out_ready is ignored. Data outputs are forced to 0.
- Simultaneous push and pop (0<count<DEPTH): both take effect; count unchanged.
- Flush:
  - At an edge, head=tail=count=0, and storage contents are don't-care.
  - A push or pop in the same cycle is discarded, including the packet on in_*.
  - The cycle after a flush: out_valid=0, in_ready=1.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. count is tracked separately and is the sole source of full/empty.
- Stable head: out_pc/out_ir hold steady while out_valid=1 and out_ready=0.
- Assertions for verification:
  - count never exceeds DEPTH.
  - No pop when empty.
  - No push when full.

Decomposition:
- rv32i_types package: add a fetch packet typedef {pc, ir} of rv32i_word/rv32i_inst_t for top-level wiring.
- The queue itself uses flat parametrised ports so other widths are reusable.
- One natural sub-module: if_id_queue_mem, a DEPTH x (PC_WIDTH+INST_WIDTH) register array with synchronous write and asynchronous read by index.
- Pointer/count control lives in the parent.

Test Plan:
- Reset, then push pc=0x60, ir=0x00000013 with out_ready=0 -> next cycle out_valid=1, out_pc=0x60, out_ir=0x00000013, count=1.
- Fill DEPTH=4 with pcs 0x60,0x64,0x68,0x6C, out_ready=0 -> count=4, in_ready=0; a fifth push of 0x70 is dropped; pops then return 0x60,0x64,0x68,0x6C in order.
- With count=2, push and pop for 6 consecutive cycles -> count stays 2, pointers wrap, outputs stay in order with no loss or duplication.
- With count=3, assert flush together with in_valid (pc=0x80) and out_ready -> next cycle count=0, out_valid=0, out_pc=0; 0x80 is never emitted.
- With count=2, assert rst together with push and pop -> next cycle count=0, in_ready=1, out_valid=0.
- Stall head: out_valid=1, out_ready=0 for 5 cycles while pushes continue -> out_pc/out_ir unchanged; count saturates at 4.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// Shared RV32I front-end types: machine word, instruction word, fetch packet.
// Latency: n/a (types only).
// Backpressure: n/a.
package if_id_queue_pkg;

   typedef logic [31:0] rv32i_word;
   typedef logic [31:0] rv32i_inst_t;

   // Fetch packet carried from IF to ID
   typedef struct packed {
      rv32i_word   pc;
      rv32i_inst_t ir;
   } fetch_pkt_t;

   localparam int unsigned IFQ_DEPTH_DEF = 4;

endpackage

// File: rtl/if_id_queue_mem.sv
// DEPTH x WIDTH register array, synchronous write, asynchronous read by index.
// Latency: write visible on the read port one cycle after the write edge.
// Backpressure: none; the parent decides when a write is allowed.
module if_id_queue_mem #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 64,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Storage: cleared on reset, otherwise written at the tail slot on a push
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   assign rdata = r_mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// Multi-entry IF/ID queue buffering {pc, ir} packets between fetch and decode.
// Latency: 1 cycle minimum (push at edge N visible after edge N), no bypass.
// Backpressure: in_ready = ~full from registered state only; flush drops all.
module if_id_queue
   import if_id_queue_pkg::*;
#(
   parameter int DEPTH      = IFQ_DEPTH_DEF,
   parameter int PC_WIDTH   = 32,
   parameter int INST_WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [PC_WIDTH-1:0]      in_pc,
   input  logic [INST_WIDTH-1:0]    in_ir,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [PC_WIDTH-1:0]      out_pc,
   output logic [INST_WIDTH-1:0]    out_ir,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int DW = PC_WIDTH + INST_WIDTH;

   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [CW-1:0] r_count;

   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic          w_we;
   logic [DW-1:0] w_rdata;

   // count alone decides full/empty so pointers can simply wrap
   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_push  = in_valid  & ~w_full;
   assign w_pop   = out_ready & ~w_empty;
   // A flush or reset in the same cycle discards the incoming packet
   assign w_we    = w_push & ~flush & ~rst;

   if_id_queue_mem #(
      .DEPTH (DEPTH),
      .WIDTH (DW)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (w_we),
      .waddr (r_tail),
      .wdata ({in_pc, in_ir}),
      .raddr (r_head),
      .rdata (w_rdata)
   );

   // Pointer and occupancy update: reset, then flush, then push/pop
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_tail <= r_tail + AW'(1);
         end
         if (w_pop) begin
            r_head <= r_head + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign in_ready  = ~w_full;
   assign out_valid = ~w_empty;
   assign out_pc    = w_empty ? '0 : w_rdata[DW-1:INST_WIDTH];
   assign out_ir    = w_empty ? '0 : w_rdata[INST_WIDTH-1:0];
   assign count     = r_count;

   // Occupancy and handshake sanity
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (r_count <= CW'(DEPTH));
         assert (!(w_pop && w_empty));
         assert (!(w_push && w_full));
      end
   end

endmodule
